// File: rtl/led_seg_output.sv
// led_seg_output: captures CPU stores to the LED and seven-segment MMIO
// windows, drives 16 LEDs and time-multiplexes an 8-digit hex display.
// All state changes on the falling edge of clk, matching the switch input block.
module led_seg_output #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LEDCtrl,
    input  logic        SegCtrl,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [15:0] led_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [31:0] ADDR_LED_ALL = 32'hFFFF_FFC0;
    localparam logic [31:0] ADDR_LED_LO  = 32'hFFFF_FFC2;
    localparam logic [31:0] ADDR_LED_HI  = 32'hFFFF_FFC4;
    localparam logic [31:0] ADDR_SEG_VAL = 32'hFFFF_FFE0;
    localparam logic [31:0] ADDR_SEG_BLK = 32'hFFFF_FFE2;
    localparam logic [31:0] ADDR_SEG_DP  = 32'hFFFF_FFE4;

    // Hex digit to active-high segment pattern, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [31:0]      seg_value_r;
    logic [7:0]       blank_mask_r;
    logic [7:0]       dp_mask_r;
    logic [CNT_W-1:0] div_cnt_r;
    logic [2:0]       digit_idx_r;

    logic led_all_we_s;
    logic led_lo_we_s;
    logic led_hi_we_s;
    logic seg_val_we_s;
    logic seg_blk_we_s;
    logic seg_dp_we_s;
    logic [3:0] cur_nibble_s;

    // Decode LED-window stores into per-register write enables.
    always_comb begin
        led_all_we_s = 1'b0;
        led_lo_we_s  = 1'b0;
        led_hi_we_s  = 1'b0;
        if (mem_write && LEDCtrl) begin
            case (address)
                ADDR_LED_ALL: led_all_we_s = 1'b1;
                ADDR_LED_LO:  led_lo_we_s  = 1'b1;
                ADDR_LED_HI:  led_hi_we_s  = 1'b1;
                default:      led_all_we_s = 1'b0;
            endcase
        end else begin
            led_all_we_s = 1'b0;
        end
    end

    // Decode seven-segment-window stores; independent of the LED window.
    always_comb begin
        seg_val_we_s = 1'b0;
        seg_blk_we_s = 1'b0;
        seg_dp_we_s  = 1'b0;
        if (mem_write && SegCtrl) begin
            case (address)
                ADDR_SEG_VAL: seg_val_we_s = 1'b1;
                ADDR_SEG_BLK: seg_blk_we_s = 1'b1;
                ADDR_SEG_DP:  seg_dp_we_s  = 1'b1;
                default:      seg_val_we_s = 1'b0;
            endcase
        end else begin
            seg_val_we_s = 1'b0;
        end
    end

    // Nibble of the value register belonging to the currently scanned digit.
    always_comb begin
        cur_nibble_s = seg_value_r[{digit_idx_r, 2'b00} +: 4];
    end

    // LED register: full or per-byte updates from the store path.
    always_ff @(negedge clk) begin
        if (!rst) begin
            led_out <= 16'h0000;
        end else if (led_all_we_s) begin
            led_out <= write_data[15:0];
        end else if (led_lo_we_s) begin
            led_out[7:0] <= write_data[7:0];
        end else if (led_hi_we_s) begin
            led_out[15:8] <= write_data[7:0];
        end
    end

    // Display configuration registers; all digits start blanked.
    always_ff @(negedge clk) begin
        if (!rst) begin
            seg_value_r  <= 32'h0000_0000;
            blank_mask_r <= 8'hFF;
            dp_mask_r    <= 8'h00;
        end else begin
            if (seg_val_we_s) begin
                seg_value_r <= write_data;
            end
            if (seg_blk_we_s) begin
                blank_mask_r <= write_data[7:0];
            end
            if (seg_dp_we_s) begin
                dp_mask_r <= write_data[7:0];
            end
        end
    end

    // Free-running scan: each digit stays selected for SCAN_DIV cycles.
    always_ff @(negedge clk) begin
        if (!rst) begin
            div_cnt_r   <= '0;
            digit_idx_r <= 3'd0;
        end else if (div_cnt_r == CNT_LAST) begin
            div_cnt_r   <= '0;
            digit_idx_r <= digit_idx_r + 3'd1;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Display output register built from the pre-edge digit and register state.
    always_ff @(negedge clk) begin
        if (!rst) begin
            seg_an  <= 8'h00;
            seg_out <= 8'h00;
        end else if (blank_mask_r[digit_idx_r]) begin
            seg_an  <= 8'h00;
            seg_out <= 8'h00;
        end else begin
            seg_an  <= 8'h01 << digit_idx_r;
            seg_out <= {dp_mask_r[digit_idx_r], hex7(cur_nibble_s)};
        end
    end

endmodule

// File: tb/tb_led_seg_output.sv
// tb_led_seg_output: directed stimulus against a cycle-count based model
// of the LED / seven-segment peripheral, plus literal spot checks.
module tb_led_seg_output;

    localparam int SD = 4;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk;
    logic        rst;
    logic        LEDCtrl;
    logic        SegCtrl;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [15:0] led_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // model state
    logic [15:0] m_led;
    logic [31:0] m_val;
    logic [7:0]  m_blank;
    logic [7:0]  m_dp;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    int          m_k;

    led_seg_output #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .LEDCtrl(LEDCtrl), .SegCtrl(SegCtrl),
        .mem_write(mem_write), .address(address), .write_data(write_data),
        .led_out(led_out), .seg_an(seg_an), .seg_out(seg_out));

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the digit shown at the k-th edge after reset release is (k / SD) mod 8.
    always @(negedge clk) begin
        int d;
        if (!rst) begin
            m_led = 16'h0; m_val = 32'h0; m_blank = 8'hFF; m_dp = 8'h0;
            m_an = 8'h0; m_seg = 8'h0; m_k = 0;
        end else begin
            d = (m_k / SD) % 8;
            if (m_blank[d]) begin
                m_an = 8'h0; m_seg = 8'h0;
            end else begin
                m_an = 8'(1 << d);
                m_seg = {m_dp[d], HEX_TAB[(m_val >> (4 * d)) & 32'hF]};
            end
            if (mem_write && LEDCtrl) begin
                if (address == 32'hFFFF_FFC0) m_led = write_data[15:0];
                if (address == 32'hFFFF_FFC2) m_led = {m_led[15:8], write_data[7:0]};
                if (address == 32'hFFFF_FFC4) m_led = {write_data[7:0], m_led[7:0]};
            end
            if (mem_write && SegCtrl) begin
                if (address == 32'hFFFF_FFE0) m_val = write_data;
                if (address == 32'hFFFF_FFE2) m_blank = write_data[7:0];
                if (address == 32'hFFFF_FFE4) m_dp = write_data[7:0];
            end
            m_k = m_k + 1;
        end
    end

    // Compare DUT with model each cycle, away from the active (falling) edge.
    always @(posedge clk) begin
        if (chk_en) begin
            check("model_led", {16'h0, led_out}, {16'h0, m_led});
            check("model_an", {24'h0, seg_an}, {24'h0, m_an});
            check("model_seg", {24'h0, seg_out}, {24'h0, m_seg});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd,
                         input logic led, input logic seg, input logic mw);
        address = a; write_data = wd; LEDCtrl = led; SegCtrl = seg; mem_write = mw;
        tick();
        mem_write = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0;
    endtask

    task automatic wait_an(input logic [7:0] v, input string nm);
        int n;
        n = 0;
        while (seg_an !== v && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check(nm, {24'h0, seg_an}, {24'h0, v});
    endtask

    initial begin
        logic [7:0] exp_seg [8];
        logic [7:0] exp_an;
        rst = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0; mem_write = 1'b0;
        address = 32'h0; write_data = 32'h0;
        tick(); tick();
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_an", {24'h0, seg_an}, 32'h0);
        check("rst_seg", {24'h0, seg_out}, 32'h0);
        chk_en = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("idle_an", {24'h0, seg_an}, 32'h0);
        end

        // LED window
        store(32'hFFFF_FFC0, 32'h0000_A5A5, 1'b1, 1'b0, 1'b1);
        check("led_all", {16'h0, led_out}, 32'hA5A5);
        store(32'hFFFF_FFC4, 32'h0000_0012, 1'b1, 1'b0, 1'b1);
        check("led_hi", {16'h0, led_out}, 32'h12A5);
        store(32'hFFFF_FFC2, 32'hFFFF_FF3C, 1'b1, 1'b0, 1'b1);
        check("led_lo", {16'h0, led_out}, 32'h123C);
        store(32'hFFFF_FFC0, 32'h0000_FFFF, 1'b0, 1'b1, 1'b1);
        check("led_noctrl", {16'h0, led_out}, 32'h123C);
        store(32'hFFFF_FFC0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
        check("led_nowrite", {16'h0, led_out}, 32'h123C);

        // Scan
        store(32'hFFFF_FFE2, 32'h0, 1'b0, 1'b1, 1'b1);
        store(32'hFFFF_FFE0, 32'h89AB_CDEF, 1'b0, 1'b1, 1'b1);
        exp_seg = '{8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F};
        wait_an(8'h80, "scan_sync7");
        wait_an(8'h01, "scan_sync0");
        for (int i = 0; i < 32; i++) begin
            exp_an = 8'h01 << (i / 4);
            check("scan_an", {24'h0, seg_an}, {24'h0, exp_an});
            check("scan_seg", {24'h0, seg_out}, {24'h0, exp_seg[i / 4]});
            tick();
        end
        check("scan_wrap", {24'h0, seg_an}, 32'h01);

        // Blank / dp
        store(32'hFFFF_FFE2, 32'h0000_00F0, 1'b0, 1'b1, 1'b1);
        store(32'hFFFF_FFE4, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        exp_seg = '{8'hF1, 8'h79, 8'h5E, 8'h39, 8'h00, 8'h00, 8'h00, 8'h00};
        wait_an(8'h00, "blk_sync_off");
        wait_an(8'h01, "blk_sync0");
        for (int i = 0; i < 32; i++) begin
            exp_an = (i < 16) ? (8'h01 << (i / 4)) : 8'h00;
            check("blk_an", {24'h0, seg_an}, {24'h0, exp_an});
            check("blk_seg", {24'h0, seg_out}, {24'h0, exp_seg[i / 4]});
            tick();
        end

        // Bad addresses with both windows selected
        store(32'hFFFF_FFC1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        store(32'hFFFF_FFE6, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        store(32'hFFFF_FFF1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        check("bad_led", {16'h0, led_out}, 32'h123C);
        for (int i = 0; i < 8; i++) tick();

        // Reset while digit 5 is about to be shown
        begin
            int n;
            n = 0;
            while (((m_k / SD) % 8) != 5 && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check("mid_sync", 32'(n), 32'd0);
        end
        store(32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        store(32'hFFFF_FFE2, 32'h0, 1'b0, 1'b1, 1'b1);
        check("mid_led", {16'h0, led_out}, 32'h0);
        check("mid_an", {24'h0, seg_an}, 32'h0);
        check("mid_seg", {24'h0, seg_out}, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post_rst_an", {24'h0, seg_an}, 32'h0);
        end
        store(32'hFFFF_FFE2, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check("unblank_seg", {24'h0, seg_out}, 32'h3F);
        check("unblank_an_nz", {31'h0, seg_an != 8'h00}, 32'h1);
        tick(); tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
